// File: rtl/add_array_pipe.sv
// Parametrised SIMD adder array with valid/ready handshake, one registered result stage,
// per-lane accumulate, full-width lane chaining, saturating modes and sticky saturation flags.
module add_array_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             mode,
  input  logic [LANES*WIDTH-1:0] adda,
  input  logic [LANES*WIDTH-1:0] addb,
  input  logic                   acc_clr,
  input  logic                   flag_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] addq,
  output logic [LANES-1:0]       carry_out,
  output logic [LANES-1:0]       sat_flag
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [2:0] {
    MODE_ADD   = 3'b000,
    MODE_ADDC  = 3'b001,
    MODE_SATU  = 3'b010,
    MODE_SATU2 = 3'b011,
    MODE_SATS  = 3'b100,
    MODE_ACC   = 3'b101,
    MODE_CHAIN = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  logic [LANES*WIDTH-1:0] addq_q, addq_d;
  logic [LANES-1:0]       carry_q, carry_d;
  logic [LANES-1:0]       flag_q, flag_d;
  logic                   valid_q, valid_d;

  logic [LANES*WIDTH-1:0] res;
  logic [LANES-1:0]       cout;
  logic [LANES-1:0]       clamp;
  logic                   accept;
  logic                   stall;

  // Unsigned half-lane add clamped to all ones on carry-out.
  function automatic logic [HALF-1:0] sat_half(input logic [HALF:0] s);
    return s[HALF] ? {HALF{1'b1}} : s[HALF-1:0];
  endfunction

  assign stall    = valid_q & ~out_ready;
  assign in_ready = out_ready | ~valid_q;
  assign accept   = in_valid & in_ready;

  // Per-lane datapath; chain_c ripples lane carries upward only in CHAIN mode.
  always_comb begin
    logic             chain_c;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [HALF:0]    lo, hi;
    res     = {(LANES*WIDTH){1'b0}};
    cout    = {LANES{1'b0}};
    clamp   = {LANES{1'b0}};
    chain_c = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a   = adda[i*WIDTH +: WIDTH];
      b   = addb[i*WIDTH +: WIDTH];
      cin = 1'b0;
      if (mode == MODE_ACC) begin
        b = acc_clr ? {WIDTH{1'b0}} : addq_q[i*WIDTH +: WIDTH];
      end else begin
        b = addb[i*WIDTH +: WIDTH];
      end
      if (mode == MODE_ADDC) begin
        cin = acc_clr ? 1'b0 : carry_q[i];
      end else if (mode == MODE_CHAIN) begin
        cin = chain_c;
      end else begin
        cin = 1'b0;
      end
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]};
      hi  = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b[WIDTH-1:HALF]};
      case (mode)
        MODE_SATU: begin
          res[i*WIDTH +: WIDTH] = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
          cout[i]  = sum[WIDTH];
          clamp[i] = sum[WIDTH];
        end
        MODE_SATU2: begin
          res[i*WIDTH +: WIDTH] = {sat_half(hi), sat_half(lo)};
          cout[i]  = hi[HALF];
          clamp[i] = hi[HALF] | lo[HALF];
        end
        MODE_SATS: begin
          // Overflow only when both operands share a sign the sum does not.
          if (~a[WIDTH-1] & ~b[WIDTH-1] & sum[WIDTH-1]) begin
            res[i*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
            clamp[i] = 1'b1;
          end else if (a[WIDTH-1] & b[WIDTH-1] & ~sum[WIDTH-1]) begin
            res[i*WIDTH +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
            clamp[i] = 1'b1;
          end else begin
            res[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
            clamp[i] = 1'b0;
          end
          cout[i] = sum[WIDTH];
        end
        default: begin
          res[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
          cout[i]  = sum[WIDTH];
          clamp[i] = 1'b0;
        end
      endcase
      chain_c = sum[WIDTH];
    end
  end

  // Next-state: a stalled result holds; acc_clr only zeroes when nothing is stored.
  always_comb begin
    addq_d  = addq_q;
    carry_d = carry_q;
    valid_d = accept | stall;
    flag_d  = (flag_clr ? {LANES{1'b0}} : flag_q) | (accept ? clamp : {LANES{1'b0}});
    if (stall) begin
      addq_d  = addq_q;
      carry_d = carry_q;
    end else if (accept) begin
      addq_d  = res;
      carry_d = cout;
    end else if (acc_clr) begin
      addq_d  = {(LANES*WIDTH){1'b0}};
      carry_d = {LANES{1'b0}};
    end else begin
      addq_d  = addq_q;
      carry_d = carry_q;
    end
  end

  // Result, carry latch, flag and valid registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      addq_q  <= {(LANES*WIDTH){1'b0}};
      carry_q <= {LANES{1'b0}};
      flag_q  <= {LANES{1'b0}};
      valid_q <= 1'b0;
    end else begin
      addq_q  <= addq_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign addq      = addq_q;
  assign carry_out = carry_q;
  assign sat_flag  = flag_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_add_array_pipe.sv
// Randomised and directed bench for add_array_pipe against an arithmetic reference model.
module tb_add_array_pipe;
  localparam int L  = 4;
  localparam int W  = 16;
  localparam int VW = 1 + 2*L + L*W;
  localparam int MX = (1 << W) - 1;

  logic           sys_clk = 1'b0;
  logic           reset_n, in_valid, in_ready, acc_clr, flag_clr, out_valid, out_ready;
  logic [2:0]     mode;
  logic [L*W-1:0] adda, addb, addq;
  logic [L-1:0]   carry_out, sat_flag;

  int n_vec = 0;
  int n_err = 0;

  int m_q[L];
  bit m_c[L];
  bit m_f[L];
  bit m_v;

  always #5 sys_clk = ~sys_clk;

  add_array_pipe #(.LANES(L), .WIDTH(W)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .adda(adda), .addb(addb), .acc_clr(acc_clr), .flag_clr(flag_clr),
    .out_valid(out_valid), .out_ready(out_ready), .addq(addq),
    .carry_out(carry_out), .sat_flag(sat_flag)
  );

  function automatic logic [VW-1:0] exp_vec();
    logic [L*W-1:0] q;
    logic [L-1:0]   c, f;
    for (int i = 0; i < L; i++) begin
      q[i*W +: W] = W'(m_q[i]);
      c[i] = m_c[i];
      f[i] = m_f[i];
    end
    return {m_v, f, c, q};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {out_valid, sat_flag, carry_out, addq};
  endfunction

  // Reference: lane results from plain integer arithmetic, CHAIN from one wide addition.
  task automatic model_step();
    bit rdy, acc, stall;
    int nq[L];
    bit nc[L], cl[L];
    int a, b, s, sa, sb, lo, hi, hm, hw;
    logic [127:0] ta, tb, ps, mk;
    rdy   = out_ready || !m_v;
    acc   = in_valid && rdy;
    stall = m_v && !out_ready;
    ta = {64'd0, adda};
    tb = {64'd0, addb};
    hw = W / 2;
    hm = (1 << hw) - 1;
    for (int i = 0; i < L; i++) begin
      a = int'(adda[i*W +: W]);
      b = int'(addb[i*W +: W]);
      cl[i] = 1'b0;
      case (mode)
        3'd1: begin s = a + b + (acc_clr ? 0 : int'(m_c[i])); nq[i] = s & MX; nc[i] = (s > MX); end
        3'd2: begin s = a + b; nq[i] = (s > MX) ? MX : s; nc[i] = (s > MX); cl[i] = (s > MX); end
        3'd3: begin
          lo = (a & hm) + (b & hm);
          hi = (a >> hw) + (b >> hw);
          nq[i] = ((hi > hm ? hm : hi) << hw) | (lo > hm ? hm : lo);
          nc[i] = (hi > hm);
          cl[i] = (hi > hm) || (lo > hm);
        end
        3'd4: begin
          sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
          sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
          s  = sa + sb;
          if (s > (1 << (W-1)) - 1) begin nq[i] = (1 << (W-1)) - 1; cl[i] = 1'b1; end
          else if (s < -(1 << (W-1))) begin nq[i] = 1 << (W-1); cl[i] = 1'b1; end
          else nq[i] = s & MX;
          nc[i] = ((a + b) > MX);
        end
        3'd5: begin s = a + (acc_clr ? 0 : m_q[i]); nq[i] = s & MX; nc[i] = (s > MX); end
        3'd6: begin
          mk = (128'd1 << ((i+1)*W)) - 128'd1;
          ps = (ta & mk) + (tb & mk);
          nq[i] = int'(ps >> (i*W)) & MX;
          nc[i] = ps[(i+1)*W];
        end
        default: begin s = a + b; nq[i] = s & MX; nc[i] = (s > MX); end
      endcase
    end
    for (int i = 0; i < L; i++) begin
      m_f[i] = (flag_clr ? 1'b0 : m_f[i]) | (acc & cl[i]);
      if (stall) begin
      end else if (acc) begin
        m_q[i] = nq[i]; m_c[i] = nc[i];
      end else if (acc_clr) begin
        m_q[i] = 0; m_c[i] = 1'b0;
      end
    end
    m_v = acc || stall;
  endtask

  task automatic cycle();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    in_valid = 1'b1; mode = m; adda = a; addb = b;
  endtask

  task automatic test_reset();
    drive(3'd0, {L{16'hFFFF}}, {L{16'h0001}});
    cycle();
    drive(3'd0, {L{16'h1234}}, {L{16'h1111}});
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < L; i++) begin m_q[i] = 0; m_c[i] = 1'b0; m_f[i] = 1'b0; end
    m_v = 1'b0;
    #1;
    n_vec++;
    if (act_vec() !== {VW{1'b0}} || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: got %h rdy=%b, expected 0 rdy=1", act_vec(), in_ready);
    end
    in_valid = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    drive(3'd1, {(L*W){1'b0}}, {(L*W){1'b0}});
    cycle();
    n_vec++;
    if (addq !== {(L*W){1'b0}} || carry_out !== {L{1'b0}} || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL post_reset_addc: got %h expected %h", act_vec(), exp_vec());
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_add_addc();
    drive(3'd0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
    cycle();
    n_vec++;
    if (addq[15:0] !== 16'h0000 || carry_out[0] !== 1'b1 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL add_carry: got %h expected %h", act_vec(), exp_vec());
    end
    drive(3'd1, 64'h0, 64'h0);
    cycle();
    n_vec++;
    if (addq[15:0] !== 16'h0001 || carry_out[0] !== 1'b0 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL addc: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic [15:0] req[4];
    logic [2:0]  md[4];
    logic [15:0] xa[4], xb[4];
    md[0] = 3'd2; xa[0] = 16'hF000; xb[0] = 16'h2000; req[0] = 16'hFFFF;
    md[1] = 3'd3; xa[1] = 16'h10F0; xb[1] = 16'h2020; req[1] = 16'h30FF;
    md[2] = 3'd4; xa[2] = 16'h7000; xb[2] = 16'h2000; req[2] = 16'h7FFF;
    md[3] = 3'd4; xa[3] = 16'h8000; xb[3] = 16'hFFFF; req[3] = 16'h8000;
    for (int k = 0; k < 4; k++) begin
      drive(md[k], {48'h0, xa[k]}, {48'h0, xb[k]});
      cycle();
      n_vec++;
      if (addq[15:0] !== req[k] || sat_flag[0] !== 1'b1 || act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL sat_%0d: got %h flag=%b, expected %h flag=1", k, addq[15:0], sat_flag[0], req[k]);
      end
    end
    drive(3'd0, 64'h1, 64'h1);
    cycle();
    n_vec++;
    if (sat_flag[0] !== 1'b1) begin
      n_err++;
      $display("FAIL flag_sticky: got %b expected 1", sat_flag[0]);
    end
    drive(3'd2, 64'hFFFF, 64'h0001);
    flag_clr = 1'b1;
    cycle();
    n_vec++;
    if (sat_flag[0] !== 1'b1 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL flag_clr_vs_set: got %h expected %h", act_vec(), exp_vec());
    end
    drive(3'd0, 64'h1, 64'h1);
    cycle();
    flag_clr = 1'b0;
    n_vec++;
    if (sat_flag !== {L{1'b0}} || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL flag_clr: got %b expected 0", sat_flag);
    end
  endtask

  task automatic test_chain();
    drive(3'd6, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
    cycle();
    n_vec++;
    if (addq !== 64'h0000_0000_0001_0000 || carry_out !== 4'b0001 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL chain: got %h c=%b, expected 0000000000010000 c=0001", addq, carry_out);
    end
  endtask

  task automatic test_acc();
    logic [15:0] req;
    for (int k = 0; k < 3; k++) begin
      drive(3'd5, 64'h5, {L{16'hAAAA}});
      acc_clr = (k == 0);
      cycle();
      req = 16'(5 * (k + 1));
      n_vec++;
      if (addq[15:0] !== req || act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL acc_%0d: got %h expected %h", k, addq[15:0], req);
      end
    end
    acc_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(3'd0, 64'h1, 64'h2);
    cycle();
    out_ready = 1'b0;
    drive(3'd0, 64'h10, 64'h20);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready_%0d: got %b expected 0", k, in_ready);
      end
      cycle();
      n_vec++;
      if (addq[15:0] !== 16'h0003 || out_valid !== 1'b1 || act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got %h expected %h", k, act_vec(), exp_vec());
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    cycle();
    n_vec++;
    if (addq[15:0] !== 16'h0030 || out_valid !== 1'b1 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL bp_release: got %h expected %h", act_vec(), exp_vec());
    end
    in_valid = 1'b0;
    cycle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 3'($urandom_range(0, 7));
      acc_clr   = ($urandom_range(0, 7) == 0);
      flag_clr  = ($urandom_range(0, 7) == 0);
      adda      = {$urandom(), $urandom()};
      addb      = {$urandom(), $urandom()};
      #1;
      exp_rdy = out_ready | ~m_v;
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rnd_ready_%0d: got %b expected %b", k, in_ready, exp_rdy);
      end
      cycle();
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rnd_%0d mode=%0d: got %h expected %h", k, mode, act_vec(), exp_vec());
      end
    end
    in_valid = 1'b0; acc_clr = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; flag_clr = 1'b0;
    mode = 3'd0; adda = '0; addb = '0;
    for (int i = 0; i < L; i++) begin m_q[i] = 0; m_c[i] = 1'b0; m_f[i] = 1'b0; end
    m_v = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    test_reset();
    test_add_addc();
    test_saturation();
    test_chain();
    test_acc();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/add_array_pipe.md
# add_array_pipe

Parametrised SIMD adder array for the graphics datapath. It generalises the fixed four-lane, 16-bit saturating add array to LANES lanes of WIDTH bits. New over that array: a valid/ready handshake, a registered output stage, per-lane accumulate, full-width lane chaining, signed saturation and sticky saturation flags. It sits between the operand fetch and the destination write stage.

## Interface
- LANES, default 4: number of independent adder lanes, 1..8.
- WIDTH, default 16: lane width in bits; even, at least 4; half-lane = WIDTH/2.
- sys_clk  in  1  the single clock; all state changes on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts the operand set this cycle.
- mode  in  3  operation select, sampled with the operands.
- adda  in  LANES*WIDTH  operand A; lane i is bits [i*WIDTH +: WIDTH].
- addb  in  LANES*WIDTH  operand B; same packing.
- acc_clr  in  1  zero the result registers and carry latches.
- flag_clr  in  1  clear the sticky saturation flags.
- out_valid  out  1  addq holds an unconsumed result.
- out_ready  in  1  consumer takes the result.
- addq  out  LANES*WIDTH  registered result; same packing.
- carry_out  out  LANES  registered per-lane carry latches.
- sat_flag  out  LANES  sticky per-lane saturation flags.

## Operation
- Accept: a transaction is accepted when `accept = in_valid & in_ready`.
- Ready: `in_ready = out_ready | ~out_valid`.
- Per-lane raw sum: `s = A + B + cin`, computed at WIDTH+1 bits. `c` = bit WIDTH of s, before any clamping.
- Mode encoding:
  - 000 ADD: wrapping add; cin = 0.
  - 001 ADDC: wrapping add; cin = that lane's carry latch. Used for multi-word precision across successive transactions.
  - 010 SATU: unsigned add; if c = 1, result = all ones.
  - 011 SATU2: each half-lane is added unsigned and saturated independently. No carry passes between halves. c = carry of the upper half.
  - 100 SATS: two's-complement add. On positive overflow the result is 0111..1; on negative overflow it is 1000..0. c = unsigned carry.
  - 101 ACC: B := current addq lane register; wrapping add; cin = 0; addb is ignored.
  - 110 CHAIN: all lanes form one LANES*WIDTH wrapping adder. Lane i cin = lane i-1 carry; lane 0 cin = 0. Each lane latches its own outgoing carry.
  - 111: reserved; behaves as ADD.
- On accept, per lane:
  - addq lane <= result.
  - carry latch <= c.
  - sat_flag |= clamp occurred, in modes 010/011/100 only.
- Sticky flags: a flag stays set until flag_clr is asserted. If flag_clr and a new clamp occur in the same cycle, the flag ends 1.
- acc_clr: synchronous. Forces every addq lane register and every carry latch to 0. out_valid is unaffected.
  - Same cycle as an accepted ACC transaction: the accumulator operand is taken as 0, so the result = adda.
  - Same cycle as an accepted ADDC transaction: cin is taken as 0.
  - In both cases the accepted result is what gets stored.
- Stall: while out_valid & ~out_ready, the following hold their values: addq, carry latches, out_valid and sat_flag. flag_clr is the only exception.

## Timing
- Reset (asynchronous assertion): addq = 0, carry_out = 0, sat_flag = 0, out_valid = 0. in_ready = 1 once reset_n is high and out_ready is don't-care.
- Latency: one cycle. Operands accepted at edge n appear on addq with out_valid = 1 after edge n.
- Throughput: one transaction per cycle while out_ready = 1.
- out_valid <= accept | (out_valid & ~out_ready).
- Back-to-back ADDC or ACC transactions see the latch or accumulator value written by the immediately preceding accepted transaction. There is no bubble.
- Reset mid-stream: the in-flight result is discarded and the next transaction sees zero carries and a zero accumulator.
- Combinational path: only in_ready depends combinationally on out_ready. All other outputs are registered.

## Test plan
- Reset: assert reset_n = 0 mid-transfer. Required: addq = 0, carry_out = 0, sat_flag = 0, out_valid = 0, in_ready = 1.
- ADD then ADDC, lane 0:
  - 0xFFFF + 0x0001 -> addq = 0x0000, carry_out[0] = 1.
  - Next cycle, 0x0000 + 0x0000 -> 0x0001, carry_out[0] = 0.
- Saturation:
  - SATU 0xF000 + 0x2000 -> 0xFFFF, sat_flag[0] = 1.
  - SATU2 0x10F0 + 0x2020 -> 0x30FF.
  - SATS 0x7000 + 0x2000 -> 0x7FFF.
  - SATS 0x8000 + 0xFFFF -> 0x8000.
  - sat_flag stays 1 until flag_clr.
- CHAIN: lane 0 = 0xFFFF + 0x0001, other lanes 0 -> lanes {0x0000, 0x0001, 0x0000, 0x0000}, carry_out = 0001b.
- ACC: acc_clr with ACC adda = 5, then two more ACC adda = 5 -> addq lane 0 = 5, 10, 15 on consecutive cycles.
- Backpressure: hold out_ready = 0 for 3 cycles after a result while driving in_valid with new data. Required: in_ready = 0, addq and carry_out unchanged. On release, exactly one result is consumed and the next input is accepted the same cycle.
